// File: rtl/control_cmd_router.sv
// Opcode-decoding byte router: rx byte -> handler strobe in 2 cycles; rx_ready drops while the hold byte waits.
// Define CMD_ROUTER_TIMEOUT_EN to abort a handler that stalls for TIMEOUT_CYCLES.
module control_cmd_router #(
  parameter int                    NUM_CMDS       = 4,
  parameter logic [NUM_CMDS*8-1:0] OPCODES        = {8'h50, 8'h4C, 8'h42, 8'h46},
  parameter int                    TIMEOUT_CYCLES = 1000000,
  localparam int                   AW             = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic [NUM_CMDS-1:0] cmd_ready_for_data,
  input  logic [NUM_CMDS-1:0] cmd_done,
  output logic [NUM_CMDS-1:0] cmd_enable,
  output logic [7:0]          cmd_data,
  output logic [NUM_CMDS-1:0] cmd_abort,
  output logic                busy,
  output logic [AW-1:0]       active_cmd,
  output logic                err_unknown,
  output logic                err_timeout
);

  typedef enum logic {IDLE, FORWARD} state_t;

  state_t              state, state_nxt;
  logic                hold_valid;
  logic [7:0]          hold_data;
  logic                match_found;
  logic [AW-1:0]       match_idx;
  logic                sel_ready, sel_done, fwd_ok;
  logic [NUM_CMDS-1:0] sel_onehot;
  logic                hold_pop, hold_clr, fwd_go, unk_go, take_cmd;
  logic                timeout_hit;

  assign sel_ready  = cmd_ready_for_data[active_cmd];
  assign sel_done   = cmd_done[active_cmd];
  assign fwd_ok     = hold_valid && sel_ready;
  assign sel_onehot = NUM_CMDS'(1) << active_cmd;
  assign busy       = (state == FORWARD);
  assign rx_ready   = !hold_valid;

  // Descending scan so the lowest matching handler index is the one left standing.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (hold_data == OPCODES[8*i +: 8]) begin
        match_found = 1'b1;
        match_idx   = AW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hold_valid && match_found) state_nxt = FORWARD;
      FORWARD: if (sel_done || timeout_hit)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_done wins over forwarding: the held byte stays put and is decoded as the next opcode.
  always_comb begin
    hold_pop = 1'b0;
    hold_clr = 1'b0;
    fwd_go   = 1'b0;
    unk_go   = 1'b0;
    take_cmd = 1'b0;
    case (state)
      IDLE: begin
        if (hold_valid) begin
          hold_pop = 1'b1;
          if (match_found) take_cmd = 1'b1;
          else             unk_go   = 1'b1;
        end
      end
      FORWARD: begin
        if (!sel_done) begin
          if (fwd_ok) begin
            fwd_go   = 1'b1;
            hold_pop = 1'b1;
          end else if (timeout_hit) begin
            hold_clr = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // A byte arriving in the cycle the old one leaves is captured, so hold_valid stays high.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'h00;
    end else if (hold_clr) begin
      hold_valid <= 1'b0;
    end else if (rx_valid && (!hold_valid || hold_pop)) begin
      hold_valid <= 1'b1;
      hold_data  <= rx_data;
    end else if (hold_pop) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_cmd  <= '0;
      cmd_enable  <= '0;
      cmd_data    <= 8'h00;
      err_unknown <= 1'b0;
    end else begin
      if (take_cmd) active_cmd <= match_idx;
      cmd_enable  <= fwd_go ? sel_onehot : '0;
      if (fwd_go) cmd_data <= hold_data;
      err_unknown <= unk_go;
    end
  end

`ifdef CMD_ROUTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] idle_cnt;

  assign timeout_hit = (state == FORWARD) && !sel_done && !fwd_ok &&
                       (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counts FORWARD cycles since entry or the last strobe; IDLE holds it at zero for the next entry.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || fwd_go || sel_done || timeout_hit) idle_cnt <= '0;
    else                                                            idle_cnt <= idle_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_abort   <= '0;
      err_timeout <= 1'b0;
    end else begin
      cmd_abort   <= timeout_hit ? sel_onehot : '0;
      err_timeout <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign cmd_abort   = '0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_control_cmd_router.sv
// Bench for control_cmd_router: directed vector table, hand-written corner sequences, then
// randomized traffic against a queue-based reference model.
module tb_control_cmd_router;

  localparam int          NUM     = 4;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] OPC     = {8'h50, 8'h4C, 8'h42, 8'h46};
`ifdef CMD_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic [NUM-1:0] rdy;
  logic [NUM-1:0] done;
  logic [NUM-1:0] cmd_enable;
  logic [7:0]     cmd_data;
  logic [NUM-1:0] cmd_abort;
  logic           busy;
  logic [1:0]     active_cmd;
  logic           err_unknown;
  logic           err_timeout;

  control_cmd_router #(.NUM_CMDS(NUM), .OPCODES(OPC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cmd_ready_for_data(rdy), .cmd_done(done), .cmd_enable(cmd_enable), .cmd_data(cmd_data),
    .cmd_abort(cmd_abort), .busy(busy), .active_cmd(active_cmd),
    .err_unknown(err_unknown), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rdy      = '0;
    done     = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " rx_ready"}, 32'(rx_ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " cmd_enable"}, 32'(cmd_enable), 32'd0);
    chk({tag, " cmd_abort"}, 32'(cmd_abort), 32'd0);
    chk({tag, " cmd_data"}, 32'(cmd_data), 32'd0);
    chk({tag, " active_cmd"}, 32'(active_cmd), 32'd0);
    chk({tag, " err_unknown"}, 32'(err_unknown), 32'd0);
    chk({tag, " err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  typedef struct {
    logic           rv;
    logic [7:0]     rd;
    logic [NUM-1:0] rdy;
    logic [NUM-1:0] done;
    logic [NUM-1:0] en;
    logic [7:0]     dat;
    logic           busy;
    logic           rx_ready;
    logic [1:0]     act;
    logic           unk;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  // Reference model: the hold register is a queue of at most one byte.
  logic [7:0]     opc [NUM];
  logic [7:0]     m_hold [$];
  bit             m_busy;
  int             m_act;
  int             m_idle;
  logic [7:0]     m_data;
  logic [NUM-1:0] m_en, m_abort;
  bit             m_unk, m_to;

  function automatic void model_step(input logic rv, input logic [7:0] rd,
                                     input logic [NUM-1:0] rdy_i, input logic [NUM-1:0] dn_i);
    bit popped  = 1'b0;
    bit cleared = 1'b0;
    int idx     = -1;
    m_en    = '0;
    m_abort = '0;
    m_unk   = 1'b0;
    m_to    = 1'b0;
    if (!m_busy) begin
      if (m_hold.size() > 0) begin
        popped = 1'b1;
        for (int i = 0; i < NUM; i++) if (idx < 0 && m_hold[0] == opc[i]) idx = i;
        if (idx >= 0) begin
          m_act  = idx;
          m_busy = 1'b1;
          m_idle = 0;
        end else begin
          m_unk = 1'b1;
        end
      end
    end else if (dn_i[m_act]) begin
      m_busy = 1'b0;
    end else if (m_hold.size() > 0 && rdy_i[m_act]) begin
      m_en   = NUM'(1) << m_act;
      m_data = m_hold[0];
      popped = 1'b1;
      m_idle = 0;
    end else if (TO_EN && m_idle == TIMEOUT - 1) begin
      m_abort = NUM'(1) << m_act;
      m_to    = 1'b1;
      cleared = 1'b1;
      m_busy  = 1'b0;
    end else begin
      m_idle++;
    end
    if (cleared) begin
      m_hold.delete();
    end else begin
      if (popped) void'(m_hold.pop_front());
      if (rv && m_hold.size() == 0) m_hold.push_back(rd);
    end
  endfunction

  initial begin
    int k;
    for (int i = 0; i < NUM; i++) opc[i] = OPC[8*i +: 8];

    //            rv rd     rdy   done  en    dat    busy rxr act unk
    tbl[0]  = '{1, 8'h46, 4'h1, 4'h0, 4'h0, 8'h00, 0, 0, 2'd0, 0};
    tbl[1]  = '{0, 8'h00, 4'h1, 4'h0, 4'h0, 8'h00, 1, 1, 2'd0, 0};
    tbl[2]  = '{1, 8'h11, 4'h1, 4'h0, 4'h0, 8'h00, 1, 0, 2'd0, 0};
    tbl[3]  = '{0, 8'h00, 4'h1, 4'h0, 4'h1, 8'h11, 1, 1, 2'd0, 0};
    tbl[4]  = '{1, 8'h22, 4'h1, 4'hE, 4'h0, 8'h00, 1, 0, 2'd0, 0};
    tbl[5]  = '{0, 8'h00, 4'h1, 4'h0, 4'h1, 8'h22, 1, 1, 2'd0, 0};
    tbl[6]  = '{1, 8'h33, 4'h1, 4'h0, 4'h0, 8'h00, 1, 0, 2'd0, 0};
    tbl[7]  = '{0, 8'h00, 4'h1, 4'h0, 4'h1, 8'h33, 1, 1, 2'd0, 0};
    tbl[8]  = '{0, 8'h00, 4'h1, 4'h1, 4'h0, 8'h00, 0, 1, 2'd0, 0};
    tbl[9]  = '{1, 8'h5A, 4'h1, 4'h0, 4'h0, 8'h00, 0, 0, 2'd0, 0};
    tbl[10] = '{0, 8'h00, 4'h1, 4'h0, 4'h0, 8'h00, 0, 1, 2'd0, 1};
    tbl[11] = '{0, 8'h00, 4'h1, 4'h0, 4'h0, 8'h00, 0, 1, 2'd0, 0};
    tbl[12] = '{1, 8'h46, 4'h1, 4'h0, 4'h0, 8'h00, 0, 0, 2'd0, 0};
    tbl[13] = '{0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 1, 1, 2'd0, 0};
    tbl[14] = '{1, 8'h42, 4'h0, 4'h0, 4'h0, 8'h00, 1, 0, 2'd0, 0};
    tbl[15] = '{0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 1, 0, 2'd0, 0};
    tbl[16] = '{0, 8'h00, 4'h1, 4'h1, 4'h0, 8'h00, 0, 0, 2'd0, 0};
    tbl[17] = '{0, 8'h00, 4'h1, 4'h0, 4'h0, 8'h00, 1, 1, 2'd1, 0};
    tbl[18] = '{0, 8'h00, 4'h1, 4'h2, 4'h0, 8'h00, 0, 1, 2'd1, 0};

    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    cyc();
    check_reset_vals("reset");
    reset = 1'b0;

    for (int r = 0; r < NV; r++) begin
      rx_valid = tbl[r].rv;
      rx_data  = tbl[r].rd;
      rdy      = tbl[r].rdy;
      done     = tbl[r].done;
      cyc();
      chk($sformatf("row%0d cmd_enable", r), 32'(cmd_enable), 32'(tbl[r].en));
      chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].busy));
      chk($sformatf("row%0d rx_ready", r), 32'(rx_ready), 32'(tbl[r].rx_ready));
      chk($sformatf("row%0d active_cmd", r), 32'(active_cmd), 32'(tbl[r].act));
      chk($sformatf("row%0d err_unknown", r), 32'(err_unknown), 32'(tbl[r].unk));
      if (tbl[r].en != 0) chk($sformatf("row%0d cmd_data", r), 32'(cmd_data), 32'(tbl[r].dat));
    end

    // Handler 2 (opcode byte 2 = 0x4C) stalls; the second payload byte is dropped.
    do_reset();
    rdy = 4'b1011;
    rx_valid = 1'b1; rx_data = 8'h4C; cyc();
    rx_valid = 1'b0; cyc();
    chk("stall busy", 32'(busy), 32'd1);
    chk("stall active_cmd", 32'(active_cmd), 32'd2);
    rx_valid = 1'b1; rx_data = 8'hAA; cyc();
    chk("stall rx_ready first", 32'(rx_ready), 32'd0);
    rx_data = 8'hBB; cyc();
    chk("stall rx_ready second", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("stall no strobe %0d", i), 32'(cmd_enable), 32'd0);
    end
    rdy = 4'b1111; cyc();
    chk("stall release enable", 32'(cmd_enable), 32'h4);
    chk("stall release data", 32'(cmd_data), 32'hAA);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("stall dropped byte %0d", i), 32'({rx_ready, cmd_enable}), 32'h10);
    end
    done = 4'b0100; cyc(); done = '0;
    chk("stall done busy", 32'(busy), 32'd0);

    // Stall timeout (or its absence) with no payload at all.
    do_reset();
    rx_valid = 1'b1; rx_data = 8'h46; cyc();
    rx_valid = 1'b0; cyc();
    chk("to entry busy", 32'(busy), 32'd1);
`ifdef CMD_ROUTER_TIMEOUT_EN
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      cyc();
      if (cmd_abort != 0) k = i;
    end
    chk("to cycles to abort", 32'(k), 32'(TIMEOUT));
    chk("to cmd_abort", 32'(cmd_abort), 32'h1);
    chk("to err_timeout", 32'(err_timeout), 32'd1);
    chk("to busy", 32'(busy), 32'd0);
    cyc();
    chk("to pulse width", 32'({cmd_abort, err_timeout}), 32'd0);
`else
    k = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (busy !== 1'b1 || cmd_abort !== '0 || err_timeout !== 1'b0) k++;
    end
    chk("no-timeout stays forwarding", 32'(k), 32'd0);
    done = 4'b0001; cyc(); done = '0;
    chk("no-timeout done busy", 32'(busy), 32'd0);
`endif

    // Reset in FORWARD with a byte held: everything clears, no abort, byte is not decoded later.
    do_reset();
    rdy = '0;
    rx_valid = 1'b1; rx_data = 8'h46; cyc();
    rx_valid = 1'b0; cyc();
    rx_valid = 1'b1; rx_data = 8'h11; cyc();
    rx_valid = 1'b0;
    chk("rst-fwd hold full", 32'({busy, rx_ready}), 32'h2);
    reset = 1'b1; cyc();
    check_reset_vals("rst-fwd");
    reset = 1'b0; cyc();
    chk("rst-fwd after1", 32'({busy, err_unknown, cmd_abort}), 32'd0);
    cyc();
    chk("rst-fwd after2", 32'({busy, err_unknown, cmd_abort}), 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    m_hold.delete();
    m_busy = 1'b0; m_act = 0; m_idle = 0; m_data = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      rx_valid = ($urandom_range(0, 9) < 4);
      rx_data  = ($urandom_range(0, 1) != 0) ? opc[$urandom_range(0, NUM - 1)] : 8'($urandom);
      for (int b = 0; b < NUM; b++) begin
        rdy[b]  = ($urandom_range(0, 3) != 0);
        done[b] = ($urandom_range(0, 29) == 0);
      end
      model_step(rx_valid, rx_data, rdy, done);
      cyc();
      chk($sformatf("rand%0d ctrl", n),
          32'({busy, active_cmd, rx_ready, cmd_enable, cmd_abort, err_unknown, err_timeout}),
          32'({m_busy, 2'(m_act), (m_hold.size() == 0), m_en, m_abort, m_unk, m_to}));
      chk($sformatf("rand%0d cmd_data", n), 32'(cmd_data), 32'(m_data));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
